// File: rtl/btm_pkg.sv
// ---------------------------------------------------------------------------
// btm_pkg
// Shared definitions for the balanced-ternary multiplier arbiter.
//   - BET trit codes and the bet_t trit type
//   - FSM state encoding used by btm_mul_arbiter
//   - constant results (all-zero trits, invalid-operand marker)
//   - has_inv_trit(): flags any invalid trit in a 2-trit operand
// ---------------------------------------------------------------------------
package btm_pkg;

    typedef logic [1:0] bet_t;

    localparam bet_t TRIT_NEG  = 2'b01;
    localparam bet_t TRIT_ZERO = 2'b11;
    localparam bet_t TRIT_POS  = 2'b10;
    localparam bet_t TRIT_INV  = 2'b00;

    // Four zero trits on the result bus, two zero trits on an operand.
    localparam logic [7:0] ZERO4 = {TRIT_ZERO, TRIT_ZERO, TRIT_ZERO, TRIT_ZERO};
    localparam logic [3:0] ZERO2 = {TRIT_ZERO, TRIT_ZERO};

    // Result reported for operands carrying an invalid trit code.
    localparam logic [7:0] INV_RESULT = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic has_inv_trit(input logic [3:0] op);
        return (bet_t'(op[1:0]) == TRIT_INV) || (bet_t'(op[3:2]) == TRIT_INV);
    endfunction

    // Identifies a trit code as one of the three legal values.
    function automatic logic is_legal_trit(input bet_t t);
        return (t == TRIT_NEG) || (t == TRIT_ZERO) || (t == TRIT_POS);
    endfunction

endpackage

// File: rtl/btm_rr_pick.sv
// ---------------------------------------------------------------------------
// btm_rr_pick
// Combinational round-robin priority pick. Scans req upward starting at ptr,
// wrapping at NUM_REQ-1, and returns the first set bit as a one-hot grant.
//
// Ports
//   req    in   NUM_REQ  request vector
//   ptr    in   PTR_W    index that has highest priority this cycle
//   gnt    out  NUM_REQ  one-hot grant (all zero when nothing requests)
//   found  out  1        some request was found
// ---------------------------------------------------------------------------
module btm_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               found
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // One extra bit so ptr+k never overflows before the wrap subtract.
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/btm_mul_arbiter.sv
// ---------------------------------------------------------------------------
// btm_mul_arbiter
// Round-robin arbiter and sequencer sharing one external 2x2-trit balanced-
// ternary multiplier between NUM_REQ requesters. One operation in flight.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no operation; pick a requester from the round-robin pointer
//   WAIT  | operands held on mul_a/mul_b, counting down MUL_LAT cycles
//   RESP  | result presented on rsp_data to the granted requester
//
// Parameters
//   NUM_REQ  number of requesters (2..8)
//   MUL_LAT  cycles from stable operands to valid mul_p (1..7)
//
// Ports
//   clk        in   1          clock, rising edge
//   rst        in   1          synchronous active-high reset
//   req_valid  in   NUM_REQ    requester i has operands
//   req_ready  out  NUM_REQ    requester i accepted this cycle
//   req_a      in   4*NUM_REQ  operand A of requester i at [4i+3:4i]
//   req_b      in   4*NUM_REQ  operand B, same packing
//   rsp_valid  out  NUM_REQ    result available for requester i
//   rsp_ready  in   NUM_REQ    requester i takes the result
//   rsp_data   out  8          shared 4-trit result bus
//   rsp_err    out  1          result came from an invalid operand
//   mul_a      out  4          operand A to the multiplier
//   mul_b      out  4          operand B to the multiplier
//   mul_p      in   8          multiplier product
//   busy       out  1          FSM not in IDLE
//
// Build option
//   BTM_ARB_TRIT_CHECK_EN  when defined, operands containing an invalid trit
//                          bypass the multiplier and answer with rsp_err=1,
//                          rsp_data=8'h00. When undefined rsp_err is 0.
// ---------------------------------------------------------------------------
module btm_mul_arbiter
    import btm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [4*NUM_REQ-1:0]   req_a,
    input  logic [4*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [7:0]             rsp_data,
    output logic                   rsp_err,
    output logic [3:0]             mul_a,
    output logic [3:0]             mul_b,
    input  logic [7:0]             mul_p,
    output logic                   busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = 3;

    arb_state_t         state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   grant;
    logic [PTR_W-1:0]   pick_idx;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_found;
    logic               accept;
    logic [3:0]         a_arr [NUM_REQ];
    logic [3:0]         b_arr [NUM_REQ];
    logic [3:0]         a_sel;
    logic [3:0]         b_sel;
    logic               op_inv;

    btm_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .found (pick_found)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[4*g+3:4*g];
        assign b_arr[g] = req_b[4*g+3:4*g];
    end

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    assign a_sel = a_arr[pick_idx];
    assign b_sel = b_arr[pick_idx];

    // Gated by rst so no requester sees a ready while the block is in reset.
    assign accept    = !rst && (state == IDLE) && pick_found;
    assign req_ready = accept ? pick_gnt : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) begin
            rsp_valid[grant] = 1'b1;
        end
    end

`ifdef BTM_ARB_TRIT_CHECK_EN
    logic rsp_err_q;

    assign op_inv  = has_inv_trit(a_sel) || has_inv_trit(b_sel);
    assign rsp_err = rsp_err_q;

    // Set at every acceptance so rsp_err always describes the current rsp_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else if (accept) begin
            rsp_err_q <= op_inv;
        end
    end
`else
    assign op_inv  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            grant    <= '0;
            cnt      <= '0;
            mul_a    <= ZERO2;
            mul_b    <= ZERO2;
            rsp_data <= ZERO4;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant <= pick_idx;
                        if (op_inv) begin
                            // Multiplier is never driven with illegal codes.
                            state    <= RESP;
                            rsp_data <= INV_RESULT;
                        end else begin
                            state <= WAIT;
                            mul_a <= a_sel;
                            mul_b <= b_sel;
                            cnt   <= CNT_W'(MUL_LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_data <= mul_p;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant]) begin
                        state <= IDLE;
                        ptr   <= (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                        mul_a <= ZERO2;
                        mul_b <= ZERO2;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btm_mul_arbiter.sv
module tb_btm_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_valid3;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  rsp_ready;

    logic [3:0]  req_ready,  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic [3:0]  mul_a, mul_b;
    logic [7:0]  mul_p;
    logic        busy;

    logic [3:0]  req_ready3, rsp_valid3;
    logic [7:0]  rsp_data3;
    logic        rsp_err3;
    logic [3:0]  mul_a3, mul_b3;
    logic [7:0]  mul_p3;
    logic        busy3;
    logic [7:0]  p3_s1, p3_s2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

`ifdef BTM_ARB_TRIT_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] vld;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural multiplier ----------------
    function automatic int dec(input logic [1:0] t);
        case (t)
            2'b01:   return -1;
            2'b10:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] enc(input int v);
        if (v < 0) return 2'b01;
        if (v > 0) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [7:0] bet_mul(input logic [3:0] a, input logic [3:0] b);
        int va, vb, p, r;
        logic [7:0] o;
        if (a[1:0] == 2'b00 || a[3:2] == 2'b00 || b[1:0] == 2'b00 || b[3:2] == 2'b00)
            return 8'h00;
        va = dec(a[1:0]) + 3 * dec(a[3:2]);
        vb = dec(b[1:0]) + 3 * dec(b[3:2]);
        p  = va * vb;
        o  = 8'h00;
        for (int k = 0; k < 4; k++) begin
            r = p % 3;
            if (r == 2)  r = -1;
            if (r == -2) r = 1;
            p = (p - r) / 3;
            o[2*k +: 2] = enc(r);
        end
        return o;
    endfunction

    assign mul_p = bet_mul(mul_a, mul_b);

    // Two register stages: product valid in the third cycle operands are held.
    always @(posedge clk) begin
        p3_s1 <= bet_mul(mul_a3, mul_b3);
        p3_s2 <= p3_s1;
    end
    assign mul_p3 = p3_s2;

    btm_mul_arbiter #(.NUM_REQ(4), .MUL_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .busy      (busy)
    );

    btm_mul_arbiter #(.NUM_REQ(4), .MUL_LAT(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid3),
        .req_ready (req_ready3),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid3),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data3),
        .rsp_err   (rsp_err3),
        .mul_a     (mul_a3),
        .mul_b     (mul_b3),
        .mul_p     (mul_p3),
        .busy      (busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every completed response handshake on dut pops one entry.
    always @(negedge clk) begin
        if (!rst && ((rsp_valid & rsp_ready) != 4'b0)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", {28'b0, rsp_valid}, 32'h0);
            end else begin
                e_mon = sb.pop_front();
                chk("rsp_valid_bit", {28'b0, rsp_valid}, {28'b0, e_mon.vld});
                chk("rsp_data",      {24'b0, rsp_data},  {24'b0, e_mon.data});
                chk("rsp_err",       {31'b0, rsp_err},   {31'b0, e_mon.err});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        req_valid  = 4'b0;
        req_valid3 = 4'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int idx);
        int n = 0;
        #1;
        while (req_ready[idx] !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) chk("ready_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_rsp(input int idx);
        int n = 0;
        while (rsp_valid[idx] !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) chk("rsp_timeout", 32'h0, 32'h1);
    endtask

    task automatic run_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] d, input logic er);
        req_a[4*idx +: 4] = a;
        req_b[4*idx +: 4] = b;
        sb.push_back({4'(1 << idx), d, er});
        req_valid[idx] = 1'b1;
        wait_ready(idx);
        tick();
        req_valid[idx] = 1'b0;
        wait_rsp(idx);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [5];
        int k, n, last, lat;
        logic [3:0] seen;

        order     = '{0, 1, 2, 3, 0};
        req_a     = 16'hFFFF;
        req_b     = 16'hFFFF;
        rsp_ready = 4'b0;

        // ---- reset values ----
        apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_req_ready", {28'b0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {28'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_data",  {24'b0, rsp_data},  32'hFF);
        chk("rst_rsp_err",   {31'b0, rsp_err},   32'h0);
        chk("rst_mul_a",     {28'b0, mul_a},     32'hF);
        chk("rst_mul_b",     {28'b0, mul_b},     32'hF);
        chk("rst_busy",      {31'b0, busy},      32'h0);
        rst = 1'b0;
        tick();

        // ---- single request, MUL_LAT=1 ----
        req_a[3:0] = 4'b1010;
        req_b[3:0] = 4'b1110;
        sb.push_back({4'b0001, 8'b11111010, 1'b0});
        req_valid = 4'b0001;
        #1;
        chk("t1_ready_c0", {28'b0, req_ready}, 32'h1);
        tick();
        req_valid = 4'b0;
        #1;
        chk("t1_mul_a",   {28'b0, mul_a},     32'hA);
        chk("t1_busy",    {31'b0, busy},      32'h1);
        chk("t1_valid_c1", {28'b0, rsp_valid}, 32'h0);
        tick();
        chk("t1_valid_c2", {28'b0, rsp_valid}, 32'h1);
        rsp_ready = 4'hF;
        tick();
        chk("t1_idle",    {31'b0, busy},      32'h0);
        chk("t1_mul_a_restore", {28'b0, mul_a}, 32'hF);

        // ---- sign checks ----
        run_op(0, 4'b0101, 4'b1110, 8'b11110101, 1'b0);
        run_op(0, 4'b0101, 4'b1101, 8'b11111010, 1'b0);

        // ---- all four requesting, pointer from 0 ----
        apply_reset();
        rsp_ready = 4'hF;
        req_a = {4'b1011, 4'b1101, 4'b0111, 4'b1010};
        req_b = {4'b1110, 4'b0101, 4'b1010, 4'b1110};
        for (int j = 0; j < 5; j++)
            sb.push_back({4'(1 << order[j]),
                          bet_mul(req_a[4*order[j] +: 4], req_b[4*order[j] +: 4]), 1'b0});
        req_valid = 4'hF;
        #1;
        k = 0; n = 0; last = 0;
        while (k < 5 && n < 60) begin
            if (req_ready != 4'b0) begin
                chk("t3_grant", {28'b0, req_ready}, 32'(1 << order[k]));
                if (k > 0) chk("t3_gap", 32'(cyc - last), 32'd3);
                last = cyc;
                k++;
            end
            tick();
            n++;
        end
        if (k < 5) chk("t3_timeout", 32'(k), 32'd5);
        req_valid = 4'b0;
        repeat (4) tick();

        // ---- rsp_ready[2] withheld for 5 cycles ----
        apply_reset();
        rsp_ready  = 4'b1011;
        req_a[11:8] = 4'b0111;
        req_b[11:8] = 4'b1010;
        sb.push_back({4'b0100, 8'hD7, 1'b0});
        req_valid = 4'b0100;
        wait_ready(2);
        tick();
        req_a[3:0] = 4'b1010;
        req_b[3:0] = 4'b1110;
        sb.push_back({4'b0001, 8'hFA, 1'b0});
        req_valid = 4'b0001;
        wait_rsp(2);
        repeat (5) begin
            #1;
            chk("t4_data",    {24'b0, rsp_data},  32'hD7);
            chk("t4_busy",    {31'b0, busy},      32'h1);
            chk("t4_noready", {28'b0, req_ready}, 32'h0);
            chk("t4_valid",   {28'b0, rsp_valid}, 32'h4);
            tick();
        end
        rsp_ready = 4'hF;
        wait_ready(0);
        tick();
        req_valid = 4'b0;
        wait_rsp(0);
        tick();

        // ---- invalid trit operand ----
        req_a[3:0] = 4'b0010;
        req_b[3:0] = 4'b1110;
        sb.push_back({4'b0001, 8'h00, CHK_EN});
        req_valid = 4'b0001;
        #1;
        chk("t6_ready", {28'b0, req_ready}, 32'h1);
        tick();
        req_valid = 4'b0;
        chk("t6_mul_a", {28'b0, mul_a}, CHK_EN ? 32'hF : 32'h2);
        lat = 1;
        while (rsp_valid[0] !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        chk("t6_latency", 32'(lat), CHK_EN ? 32'd1 : 32'd2);
        chk("t6_err",     {31'b0, rsp_err}, {31'b0, CHK_EN});
        tick();

        // ---- MUL_LAT=3: full op, then reset mid-WAIT ----
        apply_reset();
        rsp_ready  = 4'hF;
        req_a[3:0] = 4'b1010;
        req_b[3:0] = 4'b1010;
        req_valid3 = 4'b0001;
        #1;
        chk("t5_acc0", {28'b0, req_ready3}, 32'h1);
        tick();
        req_valid3 = 4'b0;
        lat = 1;
        while (rsp_valid3[0] !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        chk("t5_latency", 32'(lat), 32'd4);
        chk("t5_data",    {24'b0, rsp_data3}, 32'h96);
        tick();
        req_a[7:4] = 4'b1110;
        req_b[7:4] = 4'b1110;
        req_valid3 = 4'b0010;
        #1;
        chk("t5_acc1", {28'b0, req_ready3}, 32'h2);
        tick();
        req_valid3 = 4'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("t5_rst_req_ready", {28'b0, req_ready3}, 32'h0);
        chk("t5_rst_rsp_valid", {28'b0, rsp_valid3}, 32'h0);
        chk("t5_rst_rsp_data",  {24'b0, rsp_data3},  32'hFF);
        chk("t5_rst_rsp_err",   {31'b0, rsp_err3},   32'h0);
        chk("t5_rst_mul_a",     {28'b0, mul_a3},     32'hF);
        chk("t5_rst_mul_b",     {28'b0, mul_b3},     32'hF);
        chk("t5_rst_busy",      {31'b0, busy3},      32'h0);
        rst  = 1'b0;
        seen = 4'b0;
        repeat (6) begin
            tick();
            seen = seen | rsp_valid3;
        end
        chk("t5_no_pulse", {28'b0, seen}, 32'h0);
        req_valid3 = 4'hF;
        #1;
        chk("t5_regrant0", {28'b0, req_ready3}, 32'h1);
        tick();
        req_valid3 = 4'b0;
        lat = 1;
        while (rsp_valid3[0] !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        chk("t5_latency2", 32'(lat), 32'd4);
        chk("t5_data2",    {24'b0, rsp_data3}, 32'h96);
        repeat (3) tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/btm_mul_arbiter.md
Name: btm_mul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2-trit × 2-trit balanced-ternary multiplier (BET-encoded, combinational or pipelined) between NUM_REQ requesters.
- Each requester gets a valid/ready handshake on operands and a valid/ready handshake on the 4-trit result.
- Sits between client datapaths and the multiplier instance; the multiplier itself is external.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- MUL_LAT, 1: cycles from operands driven stable to mul_p valid, 1..7.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request i has operands.
- req_ready  out  NUM_REQ  request i accepted this cycle.
- req_a  in  4*NUM_REQ  operand A of requester i at [4i+3:4i]; 2 BET trits, low trit in [1:0].
- req_b  in  4*NUM_REQ  operand B, same packing.
- rsp_valid  out  NUM_REQ  result for requester i available.
- rsp_ready  in  NUM_REQ  requester i takes result.
- rsp_data  out  8  shared result bus: 4 BET trits, low trit in [1:0].
- rsp_err  out  1  qualifies rsp_data; invalid-operand result.
- mul_a  out  4  operand A to multiplier.
- mul_b  out  4  operand B to multiplier.
- mul_p  in  8  multiplier product.
- busy  out  1  high in any state but IDLE.

Behaviour:
- BET trit code:
  - 2'b01 = -1
  - 2'b11 = 0
  - 2'b10 = +1
  - 2'b00 = invalid
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_data = 8'hFF (all-zero trits), rsp_err = 0.
  - mul_a = 4'hF, mul_b = 4'hF, busy = 0.
  - Round-robin pointer = 0. State = IDLE.
- Reset mid-operation: any pending operation or response is discarded with no rsp_valid pulse. The pointer returns to 0.
- FSM states:
  - IDLE:
    - Choose the first i with req_valid[i], scanning from the pointer upward with wrap.
    - If one is found: pulse req_ready[i] for one cycle (combinational from state + req_valid; accept happens on that edge), latch i as grant, register A/B into mul_a/mul_b, go to WAIT.
    - If none is found: stay in IDLE.
  - WAIT:
    - mul_a/mul_b held stable.
    - Counter loads MUL_LAT-1 on entry and decrements each cycle.
    - At 0, capture mul_p into rsp_data and go to RESP.
  - RESP:
    - rsp_valid[grant] = 1, all other rsp_valid bits = 0.
    - rsp_data and rsp_err held stable.
    - When rsp_ready[grant] = 1: go to IDLE, set pointer to (grant+1) mod NUM_REQ, and restore mul_a/mul_b to 4'hF.
- Best-case throughput: one operation per MUL_LAT+2 cycles.
- Latency from acceptance to rsp_valid: MUL_LAT+1 cycles.
- Simultaneous requests: the pointer decides; the grant is fixed at acceptance.
- Later req_valid changes do not affect the operation in flight.
- req_valid dropped without acceptance: no effect.
- rsp_ready on non-granted bits: ignored.
- Only one operation is outstanding at a time; no queuing.
- Pointer wrap: NUM_REQ-1 wraps to 0; the pointer index width is clog2(NUM_REQ).

Optional Feature:
- BTM_ARB_TRIT_CHECK_EN defined:
  - At acceptance, if any trit of A or B equals 2'b00, skip WAIT and go directly to RESP.
  - rsp_data = 8'h00, rsp_err = 1.
  - mul_a/mul_b stay at 4'hF.
- Not defined:
  - Operands are forwarded unchecked and rsp_err is tied 0.
  - Invalid codes yield whatever mul_p returns.

Decomposition:
- Package btm_pkg:
  - BET codes TRIT_NEG = 2'b01, TRIT_ZERO = 2'b11, TRIT_POS = 2'b10, TRIT_INV = 2'b00.
  - typedef bet_t (2-bit).
  - FSM state enum {IDLE, WAIT, RESP}.
  - Constant ZERO4 = 8'hFF.
- One sub-module, btm_rr_pick: combinational round-robin priority pick (req vector, pointer → one-hot grant, found).
- Bench provides a behavioural 2×2-trit multiplier model with configurable MUL_LAT.

Test Plan:
- Single request, MUL_LAT=1:
  - Stimulus: req0 with A=4'b1010 (+4), B=4'b1110 (+1).
  - req_ready[0] at cycle 0, mul_a=4'b1010, rsp_valid[0] at cycle 2.
  - rsp_data=8'b11111010 (+4), rsp_err=0.
- Sign check:
  - Stimulus: A=4'b0101 (-4), B=4'b1110 (+1).
  - rsp_data=8'b11110101 (-4).
  - A=4'b0101, B=4'b1101 (-1) → 8'b11111010.
- All four request continuously, pointer 0:
  - Grants in order 0,1,2,3,0.
  - Each response is presented only to its own rsp_valid bit.
  - With rsp_ready held high, grants are 3 cycles apart.
- rsp_ready[2] held low for 5 cycles during RESP:
  - rsp_data stays stable and busy=1.
  - No req_ready on any requester until the handshake completes.
- MUL_LAT=3, rst asserted in the second WAIT cycle:
  - Next cycle all outputs at reset values.
  - No rsp_valid pulse; the next grant goes to requester 0.
- BTM_ARB_TRIT_CHECK_EN defined, A=4'b0010:
  - Response 1 cycle after acceptance with rsp_err=1, rsp_data=8'h00, mul_a remains 4'hF.
  - Same stimulus without the macro: rsp_err=0.
